// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the Tuse/Tnew hazard scoreboard.
//   DEF_*   : default geometry (3 tracked stages E/M/W, 5-bit register addresses,
//             3-bit Tuse/Tnew, 32-bit stall counter)
//   FWD_*   : forward-select encodings; FWD_RF means "use the regfile value"
// The "operand unused" marker (TUSE_NONE) is the all-ones Tuse value of whatever
// width the instance uses, so it is written as '1 where it is needed.
package hazard_scoreboard_pkg;

  localparam int unsigned DEF_STAGES = 3;
  localparam int unsigned DEF_REGW   = 5;
  localparam int unsigned DEF_TW     = 3;
  localparam int unsigned DEF_CNTW   = 32;

  localparam int unsigned FWD_RF = 0;
  localparam int unsigned FWD_E  = 1;
  localparam int unsigned FWD_M  = 2;
  localparam int unsigned FWD_W  = 3;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Youngest-match priority encoder for one D-stage source operand.
//   valid/a3/tnew : tracked entries, index 0 = youngest (E stage)
//   addr/tuse     : operand register address and Tuse (all-ones = not read)
//   hit           : some valid entry writes addr (never for $0 or unused operands)
//   idx           : index of the youngest matching entry
//   hit_tnew      : remaining Tnew of that entry
module hazard_scoreboard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned STAGES = DEF_STAGES,
  parameter int unsigned REGW   = DEF_REGW,
  parameter int unsigned TW     = DEF_TW,
  parameter int unsigned IDXW   = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic [STAGES-1:0]           valid,
  input  logic [STAGES-1:0][REGW-1:0] a3,
  input  logic [STAGES-1:0][TW-1:0]   tnew,
  input  logic [REGW-1:0]             addr,
  input  logic [TW-1:0]               tuse,
  output logic                        hit,
  output logic [IDXW-1:0]             idx,
  output logic [TW-1:0]               hit_tnew
);

  logic used;
  assign used = (addr != '0) && (tuse != '1);

  always_comb begin
    hit      = 1'b0;
    idx      = '0;
    hit_tnew = '0;
    // Scan oldest to youngest so the youngest match is the last one written.
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (used && valid[k] && (a3[k] == addr)) begin
        hit      = 1'b1;
        idx      = IDXW'(k);
        hit_tnew = tnew[k];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard unit beside the D stage of the pipeline.
//   clk, reset        : rising-edge clock, asynchronous active-low reset
//   d_a1/d_a2         : D-stage rs/rt addresses
//   d_tuse_rs/_rt     : Tuse of each operand, all-ones = operand not read
//   d_regwrite/d_a3   : D-stage instruction writes register d_a3
//   d_tnew            : D-stage Tnew counted from D
//   ext_stall         : external D-stall request
//   flush             : clear every tracked entry at the next edge
//   stall             : freeze PC/IF-ID and inject a bubble into E
//   fwd_sel_rs/_rt    : 0 = regfile, k = entry k-1 (1 = E, 2 = M, ...)
//   stall_cnt         : saturating count of hazard-caused stall cycles
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned STAGES = DEF_STAGES,
  parameter int unsigned REGW   = DEF_REGW,
  parameter int unsigned TW     = DEF_TW,
  parameter int unsigned CNTW   = DEF_CNTW,
  parameter int unsigned SELW   = $clog2(STAGES + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] d_a1,
  input  logic [REGW-1:0] d_a2,
  input  logic [TW-1:0]   d_tuse_rs,
  input  logic [TW-1:0]   d_tuse_rt,
  input  logic            d_regwrite,
  input  logic [REGW-1:0] d_a3,
  input  logic [TW-1:0]   d_tnew,
  input  logic            ext_stall,
  input  logic            flush,
  output logic            stall,
  output logic [SELW-1:0] fwd_sel_rs,
  output logic [SELW-1:0] fwd_sel_rt,
  output logic [CNTW-1:0] stall_cnt
);

  localparam int unsigned IDXW = (STAGES > 1) ? $clog2(STAGES) : 1;

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  logic [STAGES-1:0]           valid_q;
  logic [STAGES-1:0][REGW-1:0] a3_q;
  logic [STAGES-1:0][TW-1:0]   tnew_q;
  logic [CNTW-1:0]             stall_cnt_q;

  logic            hit_rs, hit_rt;
  logic [IDXW-1:0] idx_rs, idx_rt;
  logic [TW-1:0]   tnew_rs, tnew_rt;
  logic            hazard_rs, hazard_rt, hazard;

  hazard_scoreboard_match #(
    .STAGES (STAGES),
    .REGW   (REGW),
    .TW     (TW),
    .IDXW   (IDXW)
  ) u_match_rs (
    .valid    (valid_q),
    .a3       (a3_q),
    .tnew     (tnew_q),
    .addr     (d_a1),
    .tuse     (d_tuse_rs),
    .hit      (hit_rs),
    .idx      (idx_rs),
    .hit_tnew (tnew_rs)
  );

  hazard_scoreboard_match #(
    .STAGES (STAGES),
    .REGW   (REGW),
    .TW     (TW),
    .IDXW   (IDXW)
  ) u_match_rt (
    .valid    (valid_q),
    .a3       (a3_q),
    .tnew     (tnew_q),
    .addr     (d_a2),
    .tuse     (d_tuse_rt),
    .hit      (hit_rt),
    .idx      (idx_rt),
    .hit_tnew (tnew_rt)
  );

  assign hazard_rs = hit_rs && (tnew_rs > d_tuse_rs);
  assign hazard_rt = hit_rt && (tnew_rt > d_tuse_rt);
  assign hazard    = hazard_rs | hazard_rt;

  // Gated by reset so an external request cannot show a stall while reset is held.
  assign stall = reset & (hazard | ext_stall);

  // Only a value already produced (tnew==0) is forwarded from here; a pending one
  // with tnew<=tuse gets picked up further down the pipe.
  assign fwd_sel_rs = (hit_rs && tnew_rs == '0) ? SELW'(idx_rs) + SELW'(FWD_E) : SELW'(FWD_RF);
  assign fwd_sel_rt = (hit_rt && tnew_rt == '0) ? SELW'(idx_rt) + SELW'(FWD_E) : SELW'(FWD_RF);

  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      a3_q    <= '0;
      tnew_q  <= '0;
    end else if (flush) begin
      valid_q <= '0;
      a3_q    <= '0;
      tnew_q  <= '0;
    end else begin
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        a3_q[k]    <= a3_q[k-1];
        tnew_q[k]  <= dec_sat(tnew_q[k-1]);
      end
      if (!stall) begin
        valid_q[0] <= d_regwrite && (d_a3 != '0);
        a3_q[0]    <= d_a3;
        tnew_q[0]  <= dec_sat(d_tnew);
      end else begin
        valid_q[0] <= 1'b0;
        a3_q[0]    <= '0;
        tnew_q[0]  <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (hazard && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int STAGES = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_a1, d_a2, d_a3;
  logic [2:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        d_regwrite, ext_stall, flush;
  logic        stall;
  logic [1:0]  fwd_sel_rs, fwd_sel_rt;
  logic [31:0] stall_cnt;
  logic        stall_s;
  logic [1:0]  fwd_rs_s, fwd_rt_s;
  logic [1:0]  stall_cnt_s;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .d_a1       (d_a1),
    .d_a2       (d_a2),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_regwrite (d_regwrite),
    .d_a3       (d_a3),
    .d_tnew     (d_tnew),
    .ext_stall  (ext_stall),
    .flush      (flush),
    .stall      (stall),
    .fwd_sel_rs (fwd_sel_rs),
    .fwd_sel_rt (fwd_sel_rt),
    .stall_cnt  (stall_cnt)
  );

  // Narrow-counter copy on the same stimulus, to reach saturation quickly.
  hazard_scoreboard #(.CNTW(2)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .d_a1       (d_a1),
    .d_a2       (d_a2),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_regwrite (d_regwrite),
    .d_a3       (d_a3),
    .d_tnew     (d_tnew),
    .ext_stall  (ext_stall),
    .flush      (flush),
    .stall      (stall_s),
    .fwd_sel_rs (fwd_rs_s),
    .fwd_sel_rt (fwd_rt_s),
    .stall_cnt  (stall_cnt_s)
  );

  // Reference model: a history of register-writing instructions that left D,
  // each stamped with the cycle it entered E. Age 1 = E ... age STAGES = W.
  typedef struct {
    int         cyc;
    logic [4:0] a3;
    int         t;
  } rec_t;

  typedef struct {
    logic        stall;
    logic [1:0]  rs;
    logic [1:0]  rt;
    logic [31:0] cnt;
    logic [1:0]  cnt_s;
  } exp_t;

  rec_t hist[$];
  exp_t expq[$];
  int   n_cyc;
  int   model_cnt;
  int   errors;
  int   checks;

  logic       prev_stall, prev_hazard, prev_rw, prev_flush;
  logic [4:0] prev_a3;
  logic [2:0] prev_tnew;

  function automatic void look(input logic [4:0] addr, input logic [2:0] tuse,
                               output logic haz, output logic [1:0] fwd);
    int age, rem;
    haz = 1'b0;
    fwd = 2'd0;
    if (addr == 5'd0 || tuse == 3'd7) return;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].a3 == addr) begin
        age = n_cyc - hist[i].cyc + 1;
        rem = hist[i].t - age;
        if (rem < 0) rem = 0;
        haz = (rem > int'(tuse));
        fwd = (rem == 0) ? 2'(age) : 2'd0;
        return;
      end
    end
  endfunction

  task automatic op(input logic [4:0] a1, input logic [4:0] a2,
                    input logic [2:0] trs, input logic [2:0] trt,
                    input logic rw, input logic [4:0] a3, input logic [2:0] tn,
                    input logic ext = 1'b0, input logic fl = 1'b0, input logic rst = 1'b1);
    logic hrs, hrt, hz, st;
    logic [1:0] frs, frt;
    exp_t e;
    @(posedge clk);
    // Retire the cycle that just ended into the model.
    if (reset) begin
      n_cyc++;
      if (prev_flush) begin
        hist.delete();
      end else if (!prev_stall && prev_rw && prev_a3 != 5'd0) begin
        hist.push_back('{cyc: n_cyc, a3: prev_a3, t: int'(prev_tnew)});
      end
      while (hist.size() > 0 && (n_cyc - hist[0].cyc + 1) > STAGES) void'(hist.pop_front());
      if (prev_hazard) model_cnt++;
    end
    #1;
    d_a1 = a1; d_a2 = a2; d_tuse_rs = trs; d_tuse_rt = trt;
    d_regwrite = rw; d_a3 = a3; d_tnew = tn; ext_stall = ext; flush = fl; reset = rst;
    if (!rst) begin
      hist.delete();
      model_cnt = 0;
    end
    look(a1, trs, hrs, frs);
    look(a2, trt, hrt, frt);
    hz = rst && (hrs || hrt);
    st = rst && (hz || ext);
    e.stall = st;
    e.rs    = frs;
    e.rt    = frt;
    e.cnt   = 32'(model_cnt);
    e.cnt_s = (model_cnt > 3) ? 2'd3 : 2'(model_cnt);
    expq.push_back(e);
    prev_stall = st; prev_hazard = hz; prev_rw = rw; prev_flush = fl;
    prev_a3 = a3; prev_tnew = tn;
  endtask

  task automatic nop(input logic rst = 1'b1);
    op(5'd0, 5'd0, 3'd7, 3'd7, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, rst);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  // Monitor: compares each presented output set with the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("stall", 32'(stall), 32'(e.stall));
      check("fwd_sel_rs", 32'(fwd_sel_rs), 32'(e.rs));
      check("fwd_sel_rt", 32'(fwd_sel_rt), 32'(e.rt));
      check("stall_cnt", stall_cnt, e.cnt);
      check("stall_cnt_sat", 32'(stall_cnt_s), 32'(e.cnt_s));
    end
  end

  initial begin
    logic [2:0] r;
    errors = 0; checks = 0; n_cyc = 0; model_cnt = 0;
    prev_stall = 0; prev_hazard = 0; prev_rw = 0; prev_flush = 0; prev_a3 = 0; prev_tnew = 0;
    reset = 1'b0; d_a1 = 0; d_a2 = 0; d_a3 = 0; d_tuse_rs = 7; d_tuse_rt = 7;
    d_tnew = 0; d_regwrite = 0; ext_stall = 0; flush = 0;
    nop(1'b0); nop(1'b0); nop();

    // lw $1 then addu rs=$1 (tuse 1): one stall, then plain regfile read.
    op(0, 0, 7, 7, 1, 1, 3);
    op(1, 0, 1, 7, 1, 4, 2);
    op(1, 0, 1, 7, 1, 4, 2);
    nop(); nop(); nop();
    // addu $2 then beq rs=$2 (tuse 0): one stall, then forward from M.
    op(0, 0, 7, 7, 1, 2, 2);
    op(2, 0, 0, 7, 0, 0, 1);
    op(2, 0, 0, 7, 0, 0, 1);
    nop(); nop(); nop();
    // jal then jr $31: forward from E without stalling.
    op(0, 0, 7, 7, 1, 31, 1);
    op(31, 0, 0, 7, 0, 0, 0);
    nop(); nop(); nop();
    // Writes to $0 are never tracked; two writers of $3, the younger wins.
    op(0, 0, 7, 7, 1, 0, 3);
    op(0, 0, 0, 0, 0, 0, 0);
    op(0, 0, 7, 7, 1, 3, 3);
    op(0, 0, 7, 7, 1, 3, 1);
    op(3, 3, 0, 0, 0, 0, 0);
    nop(); nop(); nop();
    // Flush during a lw-use stall, then a reset pulse mid-stream.
    op(0, 0, 7, 7, 1, 5, 3);
    op(5, 5, 1, 1, 1, 6, 2, 1'b0, 1'b1);
    op(5, 5, 1, 1, 1, 6, 2);
    op(6, 0, 0, 7, 1, 7, 3);
    nop(1'b0);
    nop();
    // External stall with no hazard: bubble into E, counter untouched.
    op(0, 0, 7, 7, 1, 7, 2, 1'b1);
    op(7, 0, 0, 7, 0, 0, 0);
    nop(); nop(); nop();

    // Randomized traffic over a small register set to force frequent matches.
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] trs, trt;
      r = 3'($urandom_range(0, 4)); trs = (r == 4) ? 3'd7 : r;
      r = 3'($urandom_range(0, 4)); trt = (r == 4) ? 3'd7 : r;
      op(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), trs, trt,
         1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
         ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
         ($urandom_range(0, 299) != 0));
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
